// File: rtl/enigma_step_ctrl.sv
// Enigma rotor stepping controller: accepts a plaintext key, steps the rotor chain
// (with middle-rotor double step), waits for the chain to settle and hands out ciphertext.
//
// state | meaning
// IDLE  | ready for a key or a rotor-position load
// LOAD  | rot_set strobe to all rotors, character count cleared
// STEP  | one-cycle rotor step decision from pre-step positions
// WAIT  | key driven into the chain while it settles (SETTLE cycles)
// DONE  | ciphertext held until the consumer accepts it
module enigma_step_ctrl #(
   parameter int NOTCH_R = 21,
   parameter int NOTCH_M = 4,
   parameter int SETTLE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_set_in,
   input  logic        key_valid_in,
   input  logic [4:0]  key_char_in,
   output logic        key_ready_out,
   input  logic [4:0]  pos_r_in,
   input  logic [4:0]  pos_m_in,
   input  logic [4:0]  pos_l_in,
   output logic        rot_set_out,
   output logic [2:0]  rot_step_out,
   output logic [4:0]  dp_char_out,
   input  logic [4:0]  dp_char_in,
   output logic        ct_valid_out,
   output logic [4:0]  ct_char_out,
   input  logic        ct_ready_in,
   output logic        err_out,
   output logic [15:0] char_count_out
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STEP,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  char_q;
   logic [3:0]  settle_cnt;
   logic [4:0]  ct_char_q;
   logic [15:0] count_q;
   logic        err_q;
   logic        key_accept;
   logic        key_reject;
   logic        settle_tc;
   logic        err_nxt;
   logic        notch_r_hit;
   logic        notch_m_hit;

   // The left rotor never gates a step; its position is carried for completeness only.
   logic        pos_l_unused;
   assign pos_l_unused = ^pos_l_in;

   assign notch_r_hit = (pos_r_in == 5'(NOTCH_R));
   assign notch_m_hit = (pos_m_in == 5'(NOTCH_M));
   assign settle_tc   = (settle_cnt == 4'd0);

   always_comb begin
      state_nxt     = state;
      key_ready_out = 1'b0;
      rot_set_out   = 1'b0;
      rot_step_out  = 3'b000;
      dp_char_out   = 5'd0;
      ct_valid_out  = 1'b0;
      key_accept    = 1'b0;
      key_reject    = 1'b0;
      case (state)
         ST_IDLE: begin
            key_ready_out = !cfg_set_in;
            if (cfg_set_in) begin
               state_nxt = ST_LOAD;
            end else if (key_valid_in) begin
               if (key_char_in <= 5'd25) begin
                  key_accept = 1'b1;
                  state_nxt  = ST_STEP;
               end else begin
                  key_reject = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            rot_set_out = 1'b1;
            state_nxt   = ST_IDLE;
         end
         ST_STEP: begin
            // Middle rotor steps on its own notch too: the historical double step.
            rot_step_out = {notch_m_hit, notch_r_hit | notch_m_hit, 1'b1};
            dp_char_out  = char_q;
            state_nxt    = ST_WAIT;
         end
         ST_WAIT: begin
            dp_char_out = char_q;
            if (settle_tc) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            ct_valid_out = 1'b1;
            if (ct_ready_in) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign err_nxt = key_reject | (cfg_set_in & (state != ST_IDLE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         char_q     <= 5'd0;
         settle_cnt <= 4'd0;
         ct_char_q  <= 5'd0;
         count_q    <= 16'd0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
         if (key_accept) char_q <= key_char_in;
         if (state == ST_STEP) begin
            settle_cnt <= 4'(SETTLE - 1);
         end else if (state == ST_WAIT && !settle_tc) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
         if (state == ST_IDLE && cfg_set_in) begin
            count_q <= 16'd0;
         end else if (state == ST_WAIT && settle_tc) begin
            count_q   <= count_q + 16'd1;
            ct_char_q <= dp_char_in;
         end
      end
   end

   assign ct_char_out    = ct_char_q;
   assign char_count_out = count_q;
   assign err_out        = err_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed bench for enigma_step_ctrl: stepping patterns, latency, backpressure,
// rejected inputs and mid-character reset.
module tb_enigma_step_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_set;
   logic        key_valid;
   logic [4:0]  key_char;
   logic        key_ready;
   logic [4:0]  pos_r, pos_m, pos_l;
   logic        rot_set;
   logic [2:0]  rot_step;
   logic [4:0]  dp_char;
   logic [4:0]  dp_in;
   logic        ct_valid;
   logic [4:0]  ct_char;
   logic        ct_ready;
   logic        err;
   logic [15:0] char_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_cnt = 16'd0;

   always #5 clk = ~clk;

   enigma_step_ctrl #(.NOTCH_R(21), .NOTCH_M(4), .SETTLE(1)) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_set_in     (cfg_set),
      .key_valid_in   (key_valid),
      .key_char_in    (key_char),
      .key_ready_out  (key_ready),
      .pos_r_in       (pos_r),
      .pos_m_in       (pos_m),
      .pos_l_in       (pos_l),
      .rot_set_out    (rot_set),
      .rot_step_out   (rot_step),
      .dp_char_out    (dp_char),
      .dp_char_in     (dp_in),
      .ct_valid_out   (ct_valid),
      .ct_char_out    (ct_char),
      .ct_ready_in    (ct_ready),
      .err_out        (err),
      .char_count_out (char_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // One full character; hold = DONE cycles with ct_ready low before release.
   task automatic run_key(input logic [4:0] k, input logic [4:0] pr, input logic [4:0] pm,
                          input logic [4:0] dpv, input logic [2:0] exp_step, input int hold);
      pos_r = pr; pos_m = pm; key_char = k; key_valid = 1'b1; dp_in = dpv;
      ct_ready = (hold == 0);
      #1 chk("accept_ready", key_ready, 1);
      tick;
      key_valid = 1'b0;
      #1;
      chk("step_vec", rot_step, exp_step);
      chk("step_dp", dp_char, k);
      chk("step_ctv", ct_valid, 0);
      tick; #1;
      chk("wait_step", rot_step, 0);
      chk("wait_dp", dp_char, k);
      chk("wait_ctv", ct_valid, 0);
      tick; #1;
      exp_cnt = exp_cnt + 16'd1;
      chk("done_ctv", ct_valid, 1);
      chk("done_ct", ct_char, dpv);
      chk("done_cnt", char_count, exp_cnt);
      chk("done_dp", dp_char, 0);
      chk("done_kr", key_ready, 0);
      for (int i = 0; i < hold; i++) begin
         tick; #1;
         chk("hold_ctv", ct_valid, 1);
         chk("hold_ct", ct_char, dpv);
         chk("hold_kr", key_ready, 0);
      end
      ct_ready = 1'b1;
      tick; #1;
      chk("release_ctv", ct_valid, 0);
      chk("release_kr", key_ready, 1);
   endtask

   initial begin
      reset = 1'b0; cfg_set = 1'b0; key_valid = 1'b0; key_char = 5'd0;
      pos_r = 5'd0; pos_m = 5'd0; pos_l = 5'd0; dp_in = 5'd0; ct_ready = 1'b1;
      #2;
      chk("rst_ctv", ct_valid, 0);
      chk("rst_cnt", char_count, 0);
      chk("rst_step", rot_step, 0);
      #10 reset = 1'b1;
      tick; #1;
      chk("idle_kr", key_ready, 1);
      chk("idle_set", rot_set, 0);
      chk("idle_step", rot_step, 0);
      chk("idle_dp", dp_char, 0);
      chk("idle_ctv", ct_valid, 0);
      chk("idle_ct", ct_char, 0);
      chk("idle_err", err, 0);
      chk("idle_cnt", char_count, 0);

      // set and key together: set wins
      cfg_set = 1'b1; key_valid = 1'b1; key_char = 5'd3;
      #1 chk("set_kr", key_ready, 0);
      tick;
      cfg_set = 1'b0; key_valid = 1'b0;
      #1;
      chk("load_set", rot_set, 1);
      chk("load_step", rot_step, 0);
      chk("load_kr", key_ready, 0);
      tick; #1;
      chk("post_load_set", rot_set, 0);
      chk("post_load_kr", key_ready, 1);
      chk("post_load_err", err, 0);

      // ADU -> ADV -> AEW -> BFX
      pos_l = 5'd0;
      run_key(5'd0, 5'd20, 5'd3, 5'd7,  3'b001, 0);
      run_key(5'd0, 5'd21, 5'd3, 5'd12, 3'b011, 0);
      run_key(5'd5, 5'd22, 5'd4, 5'd25, 3'b111, 0);

      // backpressure
      run_key(5'd25, 5'd1, 5'd1, 5'd9, 3'b001, 5);

      // out-of-range key rejected
      key_valid = 1'b1; key_char = 5'd26;
      tick;
      key_valid = 1'b0;
      #1;
      chk("bad_err", err, 1);
      chk("bad_step", rot_step, 0);
      chk("bad_cnt", char_count, exp_cnt);
      chk("bad_kr", key_ready, 1);
      tick; #1;
      chk("bad_err_end", err, 0);
      chk("bad_step2", rot_step, 0);

      // cfg_set while WAIT is ignored and flagged
      pos_r = 5'd0; pos_m = 5'd0; key_char = 5'd2; key_valid = 1'b1; dp_in = 5'd17; ct_ready = 1'b0;
      tick; key_valid = 1'b0;
      tick;
      cfg_set = 1'b1;
      tick;
      cfg_set = 1'b0;
      #1;
      exp_cnt = exp_cnt + 16'd1;
      chk("wset_err", err, 1);
      chk("wset_set", rot_set, 0);
      chk("wset_ctv", ct_valid, 1);
      chk("wset_cnt", char_count, exp_cnt);
      tick; #1;
      chk("wset_err_end", err, 0);
      chk("wset_set2", rot_set, 0);
      ct_ready = 1'b1;
      tick; #1;
      chk("wset_idle", key_ready, 1);

      // load clears count
      cfg_set = 1'b1;
      tick;
      cfg_set = 1'b0;
      tick; #1;
      exp_cnt = 16'd0;
      chk("clr_cnt", char_count, 0);

      run_key(5'd4, 5'd21, 5'd9, 5'd1, 3'b011, 0);

      // reset during WAIT aborts the character
      pos_r = 5'd0; pos_m = 5'd0; key_char = 5'd8; key_valid = 1'b1; dp_in = 5'd20;
      tick; key_valid = 1'b0;
      tick; #1;
      chk("pre_rst_dp", dp_char, 8);
      reset = 1'b0;
      #1;
      chk("arst_dp", dp_char, 0);
      chk("arst_ctv", ct_valid, 0);
      chk("arst_cnt", char_count, 0);
      chk("arst_ct", ct_char, 0);
      #1 reset = 1'b1;
      exp_cnt = 16'd0;
      for (int i = 0; i < 3; i++) begin
         tick; #1;
         chk("post_rst_ctv", ct_valid, 0);
         chk("post_rst_cnt", char_count, 0);
      end
      run_key(5'd11, 5'd2, 5'd4, 5'd6, 3'b111, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
